uart_seg_console: RTL

Byte-level console controller between the UART core and the 595 seven-segment driver. It shifts received bytes into an N-byte display history and toggles an activity LED. It also queues outgoing bytes (a key-press counter and optional echo of received bytes) in a TX FIFO and drains them to the UART transmitter with a busy handshake. It replaces the ad-hoc 4-register shift and undebounced key logic of the top-level test designs.

---
 rtl/uart_seg_console_pkg.sv | 30 +++
 rtl/uart_seg_console_sync_fifo.sv | 62 ++++++
 rtl/uart_seg_console.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_seg_console_pkg.sv
// Shared definitions for the UART seven-segment console: TX FSM states,
// byte width, default key counter value and a pointer-width helper.
package uart_seg_console_pkg;

    localparam int BYTE_W = 8;

    // Key counter starts at ASCII '0' so the first press sends '1'.
    localparam logic [BYTE_W-1:0] INIT_CHAR_DEFAULT = 8'h30;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_HOLD = 2'd2,
        TX_WAIT = 2'd3
    } tx_state_t;

    // Number of bits needed to address 'value' entries (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_seg_console_sync_fifo.sv
// Single-clock circular FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter; the level
// is simply the pointer difference. Read data is registered and only
// changes on an accepted read.
module uart_seg_console_sync_fifo
    import uart_seg_console_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Writes into a full FIFO and reads from an empty one are ignored.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);

    // Storage array; contents need no reset because the pointers gate access.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance and registered read data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + PW'(1);
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_seg_console.sv
// Byte-level console between the UART core and the 595 display driver.
// Received bytes shift into a display history and toggle an activity LED.
// A debounced key increments an ASCII counter whose value is queued for
// transmission, optionally alongside an echo of every received byte.
//
// TX handshake: tx_send is a one-cycle start pulse with tx_data already
// valid; the transmitter raises tx_busy no later than the cycle after
// tx_send and drops it when done. tx_data stays stable until the next
// IDLE->SEND transition, so it is held for the whole busy period.
module uart_seg_console
    import uart_seg_console_pkg::*;
#(
    parameter int              NUM_DIGITS      = 4,
    parameter int              FIFO_DEPTH      = 16,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter logic [BYTE_W-1:0] INIT_CHAR     = INIT_CHAR_DEFAULT
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         key_in,
    input  logic                         echo_en,
    input  logic                         rx_valid,
    input  logic [BYTE_W-1:0]            rx_data,
    input  logic                         tx_busy,
    output logic                         tx_send,
    output logic [BYTE_W-1:0]            tx_data,
    output logic [BYTE_W*NUM_DIGITS-1:0] disp_data,
    output logic                         led,
    output logic [7:0]                   drop_count,
    output logic [clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DISP_W = BYTE_W * NUM_DIGITS;
    localparam int DB_W   = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // Key path state
    logic              key_meta;
    logic              key_sync;
    logic              key_last;
    logic              key_db;
    logic [DB_W-1:0]   db_cnt;
    logic              key_press;
    logic [BYTE_W-1:0] key_count;
    logic              key_pending;

    // FIFO write arbitration
    logic              echo_wr;
    logic              key_wr;
    logic              fifo_wr;
    logic [BYTE_W-1:0] fifo_wr_data;
    logic              fifo_rd;
    logic [BYTE_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    // TX FSM
    tx_state_t         tx_state;
    tx_state_t         tx_state_d;

    // Display history shift and activity LED toggle on each received byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_data <= '0;
            led       <= 1'b0;
        end else if (rx_valid) begin
            disp_data <= (disp_data << BYTE_W) | DISP_W'(rx_data);
            led       <= ~led;
        end
    end

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // A press is the cycle the debounced level would fall from 1 to 0.
    assign key_press = (key_sync == key_last) && (db_cnt == DB_MAX) &&
                       key_db && !key_last;

    // Debounce: any change of the synchronised level restarts the count;
    // the debounced level follows only after the count has run out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_last <= 1'b1;
            key_db   <= 1'b1;
            db_cnt   <= '0;
        end else if (key_sync != key_last) begin
            key_last <= key_sync;
            db_cnt   <= '0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DB_W'(1);
        end else if (key_db != key_last) begin
            key_db <= key_last;
        end
    end

    // Echo writes win; a pending key event uses the first free, non-full cycle.
    assign echo_wr      = rx_valid && echo_en;
    assign key_wr       = key_pending && !echo_wr && !fifo_full;
    assign fifo_wr      = (echo_wr && !fifo_full) || key_wr;
    assign fifo_wr_data = echo_wr ? rx_data : key_count;

    // Key counter and single pending event; a new press re-arms the event
    // so the latest counter value is what eventually gets queued.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_count   <= INIT_CHAR;
            key_pending <= 1'b0;
        end else if (key_press) begin
            key_count   <= key_count + 8'd1;
            key_pending <= 1'b1;
        end else if (key_wr) begin
            key_pending <= 1'b0;
        end
    end

    // Saturating count of echo bytes lost to a full FIFO.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_count <= '0;
        end else if (echo_wr && fifo_full && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    uart_seg_console_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (fifo_wr),
        .wr_data   (fifo_wr_data),
        .rd_en     (fifo_rd),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // The FIFO read register only loads on a pop, which happens solely on
    // IDLE->SEND, so it doubles as the held tx_data register.
    assign tx_data = fifo_rd_data;

    // TX FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_d;
        end
    end

    // TX FSM next state, FIFO pop and start pulse.
    always_comb begin
        tx_state_d = tx_state;
        fifo_rd    = 1'b0;
        tx_send    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_send    = 1'b1;
                tx_state_d = TX_HOLD;
            end
            TX_HOLD: begin
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

endmodule
